// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Multi-cycle WIDTH-bit ripple subtractor computing a - b - bin.
//             Each clock handles one DIGIT_W-bit digit, starting with the
//             least significant digit. Valid/ready handshake on input and on
//             output, with one operation in flight at a time.
//  Options  : ADDSUB_MODE_EN - adds an op port (1 = a + b + bin, carry-out
//             on bout). When undefined, the block only subtracts and the
//             datapath has no add/sub mux.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH   = 128,  // operand/result width
  parameter int DIGIT_W = 8     // bits per cycle; must divide WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef ADDSUB_MODE_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int c_N     = WIDTH / DIGIT_W;
  localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_BUSY = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_borrow;
  logic [c_CNT_W-1:0] r_cnt;
`ifdef ADDSUB_MODE_EN
  logic               r_op;
`endif

  logic [DIGIT_W:0]   w_dig_sub;
  logic [DIGIT_W:0]   w_dig;
  logic [WIDTH-1:0]   w_res_next;

  // One digit of a - b - borrow; the extra top bit is set when negative.
  assign w_dig_sub = {1'b0, r_a[DIGIT_W-1:0]}
                   - {1'b0, r_b[DIGIT_W-1:0]}
                   - {{DIGIT_W{1'b0}}, r_borrow};

`ifdef ADDSUB_MODE_EN
  logic [DIGIT_W:0] w_dig_add;

  // One digit of a + b + carry; the top bit is the carry-out.
  assign w_dig_add = {1'b0, r_a[DIGIT_W-1:0]}
                   + {1'b0, r_b[DIGIT_W-1:0]}
                   + {{DIGIT_W{1'b0}}, r_borrow};

  // Select the digit operation latched with the operands.
  always_comb begin
    w_dig = w_dig_sub;
    if (r_op) begin
      w_dig = w_dig_add;
    end
  end
`else
  assign w_dig = w_dig_sub;
`endif

  // New digits enter at the MSB end, so after N steps digit 0 is at the LSB.
  generate
    if (c_N > 1) begin : g_shift_multi
      assign w_res_next = {w_dig[DIGIT_W-1:0], r_res[WIDTH-1:DIGIT_W]};
    end else begin : g_shift_single
      assign w_res_next = w_dig[DIGIT_W-1:0];
    end
  endgenerate

  // Control FSM and digit-serial datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
`ifdef ADDSUB_MODE_EN
      r_op     <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
`ifdef ADDSUB_MODE_EN
            r_op     <= op;
`endif
            r_state  <= c_ST_BUSY;
          end
        end
        c_ST_BUSY: begin
          r_res    <= w_res_next;
          r_a      <= r_a >> DIGIT_W;
          r_b      <= r_b >> DIGIT_W;
          r_borrow <= w_dig[DIGIT_W];
          r_cnt    <= r_cnt + c_CNT_W'(1);
          // DONE is always entered before a result can be consumed.
          if (r_cnt == c_LAST) begin
            r_state <= c_ST_DONE;
          end
        end
        c_ST_DONE: begin
          if (out_ready) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode straight from the state register.
  assign in_ready  = (r_state == c_ST_IDLE);
  assign busy      = (r_state == c_ST_BUSY);
  assign out_valid = (r_state == c_ST_DONE);
  assign diff      = r_res;
  assign bout      = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor (WIDTH=128,
//             DIGIT_W=8). Directed corner cases plus random operands checked
//             against a whole-word arithmetic reference model. Exercises the
//             op port when ADDSUB_MODE_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int WIDTH   = 128;
  localparam int DIGIT_W = 8;
  localparam int N       = WIDTH / DIGIT_W;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             op_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
`ifdef ADDSUB_MODE_EN
    .op        (op_sel),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .busy      (busy)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word arithmetic, {bout, diff}.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma,
                                           input logic [WIDTH-1:0] mb,
                                           input logic mbin, input logic mop);
    logic [WIDTH:0] r;
    if (mop) begin
      r = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mbin};
    end else begin
      r[WIDTH-1:0] = ma - mb - {{(WIDTH-1){1'b0}}, mbin};
      r[WIDTH]     = ({1'b0, mb} + {{WIDTH{1'b0}}, mbin}) > {1'b0, ma};
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [WIDTH:0] obs,
                       input logic [WIDTH:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Wait for in_ready, present operands for one edge, then scramble inputs.
  task automatic start_op(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb,
                          input logic sbin, input logic sop);
    int k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1; a = sa; b = sb; bin = sbin; op_sel = sop;
    @(posedge clk); #1;
    in_valid = 1'b0; a = rand128(); b = rand128(); bin = $urandom_range(0, 1);
    check("accepted_busy", busy, 1);
  endtask

  // Count cycles from the accept edge until out_valid rises.
  task automatic wait_done(input string tag);
    int k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check(tag, k, N);
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] ca,
                              input logic [WIDTH-1:0] cb, input logic cbin,
                              input logic cop);
    check(tag, {bout, diff}, model(ca, cb, cbin, cop));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_out_valid", out_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_diff_bout"}, {bout, diff}, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] ra, rb, na, nb;
    logic             rbin, rop;
    logic [WIDTH:0]   held;
    int               seen;

    ones      = '1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    op_sel    = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: 5 - 3 with latency check.
    start_op(128'd5, 128'd3, 1'b0, 1'b0);
    wait_done("t1_latency");
    check("t1_result", {bout, diff}, {1'b0, 128'd2});
    handshake();

    // 2: 0 - 1 wraps.
    start_op(128'd0, 128'd1, 1'b0, 1'b0);
    wait_done("t2_latency");
    check("t2_result", {bout, diff}, {1'b1, ones});
    handshake();

    // 3: all ones minus all ones minus borrow-in.
    start_op(ones, ones, 1'b1, 1'b0);
    wait_done("t3_latency");
    check("t3_result", {bout, diff}, {1'b1, ones});
    handshake();

    // 4: consumer stalls while a new request is pending.
    ra = rand128(); rb = rand128();
    start_op(ra, rb, 1'b0, 1'b0);
    wait_done("t4_latency");
    held = model(ra, rb, 1'b0, 1'b0);
    check("t4_result", {bout, diff}, held);
    na = rand128(); nb = rand128();
    in_valid = 1'b1; a = na; b = nb; bin = 1'b1; op_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_hold_out_valid", out_valid, 1);
      check("t4_hold_in_ready", in_ready, 0);
      check("t4_hold_result", {bout, diff}, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t4_idle_in_ready", in_ready, 1);
    check("t4_idle_busy", busy, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; a = rand128(); b = rand128(); bin = 1'b0;
    check("t4_second_busy", busy, 1);
    wait_done("t4_second_latency");
    check("t4_second_result", {bout, diff}, model(na, nb, 1'b1, 1'b0));
    handshake();

    // 5: asynchronous reset mid-operation.
    start_op(rand128(), rand128(), 1'b1, 1'b0);
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("t5_busy_before_rst", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    @(posedge clk); #1;
    check_reset_outputs("t5_held");
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("t5_no_out_valid", seen, 0);
    start_op(128'd10, 128'd4, 1'b0, 1'b0);
    wait_done("t5_latency");
    check("t5_result", {bout, diff}, {1'b0, 128'd6});
    handshake();

`ifdef ADDSUB_MODE_EN
    // 6: add mode overflow.
    start_op(ones, 128'd1, 1'b0, 1'b1);
    wait_done("t6_latency");
    check("t6_result", {bout, diff}, {1'b1, 128'd0});
    handshake();
`endif

    // Random operations; out_ready sometimes held high throughout.
    for (int i = 0; i < 24; i++) begin
      ra   = rand128();
      rb   = (i % 6 == 0) ? ra : rand128();
      rbin = 1'($urandom_range(0, 1));
`ifdef ADDSUB_MODE_EN
      rop  = 1'($urandom_range(0, 1));
`else
      rop  = 1'b0;
`endif
      out_ready = 1'($urandom_range(0, 1));
      start_op(ra, rb, rbin, rop);
      wait_done("rand_latency");
      check_result("rand_result", ra, rb, rbin, rop);
      handshake();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
